// File: rtl/mem_stage_pkg.sv
// Shared configuration for the memory stage: op encodings, widths,
// FSM state encoding and small op-decoding helpers.
package mem_stage_pkg;

    localparam int RegLen     = 32;
    localparam int AddrLen    = 32;
    localparam int RegAddrLen = 5;
    localparam int ALU_Len    = 5;

    localparam logic ResetEnable  = 1'b0;
    localparam logic WriteEnable  = 1'b1;
    localparam logic WriteDisable = 1'b0;

    localparam logic [ALU_Len-1:0] ALU_NOP    = 5'd0;
    localparam logic [ALU_Len-1:0] ALU_ADD    = 5'd1;
    localparam logic [ALU_Len-1:0] ALU_SUB    = 5'd2;
    localparam logic [ALU_Len-1:0] ALU_AND    = 5'd3;
    localparam logic [ALU_Len-1:0] ALU_OR     = 5'd4;
    localparam logic [ALU_Len-1:0] ALU_XOR    = 5'd5;
    localparam logic [ALU_Len-1:0] ALU_SLL    = 5'd6;
    localparam logic [ALU_Len-1:0] ALU_SRL    = 5'd7;
    localparam logic [ALU_Len-1:0] ALU_SRA    = 5'd8;
    localparam logic [ALU_Len-1:0] ALU_SLT    = 5'd9;
    localparam logic [ALU_Len-1:0] ALU_BRANCH = 5'd10;
    localparam logic [ALU_Len-1:0] ALU_LB     = 5'd16;
    localparam logic [ALU_Len-1:0] ALU_LH     = 5'd17;
    localparam logic [ALU_Len-1:0] ALU_LW     = 5'd18;
    localparam logic [ALU_Len-1:0] ALU_LBU    = 5'd19;
    localparam logic [ALU_Len-1:0] ALU_LHU    = 5'd20;
    localparam logic [ALU_Len-1:0] ALU_SB     = 5'd21;
    localparam logic [ALU_Len-1:0] ALU_SH     = 5'd22;
    localparam logic [ALU_Len-1:0] ALU_SW     = 5'd23;

    typedef enum logic [1:0] {
        MEM_IDLE  = 2'd0,
        MEM_READ  = 2'd1,
        MEM_WRITE = 2'd2,
        MEM_DONE  = 2'd3
    } mem_state_t;

    function automatic logic is_load(input logic [ALU_Len-1:0] op);
        return op inside {ALU_LB, ALU_LH, ALU_LW, ALU_LBU, ALU_LHU};
    endfunction

    function automatic logic is_store(input logic [ALU_Len-1:0] op);
        return op inside {ALU_SB, ALU_SH, ALU_SW};
    endfunction

    // Number of bytes moved over the 8-bit RAM port; 0 for non-memory ops.
    function automatic logic [2:0] access_bytes(input logic [ALU_Len-1:0] op);
        case (op)
            ALU_LB, ALU_LBU, ALU_SB: return 3'd1;
            ALU_LH, ALU_LHU, ALU_SH: return 3'd2;
            ALU_LW, ALU_SW:          return 3'd4;
            default:                 return 3'd0;
        endcase
    endfunction

endpackage

// File: rtl/mem_stage_if.sv
// Execute->memory bundle, writeback bundle and byte-wide RAM port of the memory stage.
interface mem_stage_if
    import mem_stage_pkg::*;
#(
    parameter int ADDR_LEN     = AddrLen,
    parameter int REG_LEN      = RegLen,
    parameter int REG_ADDR_LEN = RegAddrLen,
    parameter int ALU_LEN      = ALU_Len
);
    logic                    in_valid;
    logic [REG_LEN-1:0]      rd_data_i;
    logic [REG_ADDR_LEN-1:0] rd_addr_i;
    logic                    rd_enable_i;
    logic [ADDR_LEN-1:0]     mem_addr_i;
    logic [ALU_LEN-1:0]      alu_op_i;
    logic [REG_LEN-1:0]      mem_wdata_i;
    logic                    stall_o;
    logic                    out_valid;
    logic [REG_LEN-1:0]      rd_data_o;
    logic [REG_ADDR_LEN-1:0] rd_addr_o;
    logic                    rd_enable_o;
    logic [ADDR_LEN-1:0]     ram_addr_o;
    logic [7:0]              ram_wdata_o;
    logic                    ram_wr_o;
    logic [7:0]              ram_rdata_i;

    modport slave (
        input  in_valid, rd_data_i, rd_addr_i, rd_enable_i, mem_addr_i, alu_op_i,
               mem_wdata_i, ram_rdata_i,
        output stall_o, out_valid, rd_data_o, rd_addr_o, rd_enable_o,
               ram_addr_o, ram_wdata_o, ram_wr_o
    );

    modport master (
        output in_valid, rd_data_i, rd_addr_i, rd_enable_i, mem_addr_i, alu_op_i,
               mem_wdata_i, ram_rdata_i,
        input  stall_o, out_valid, rd_data_o, rd_addr_o, rd_enable_o,
               ram_addr_o, ram_wdata_o, ram_wr_o
    );
endinterface

// File: rtl/mem_load_ext.sv
// Sign/zero extension of an assembled little-endian load word according to the load op.
module mem_load_ext
    import mem_stage_pkg::*;
#(
    parameter int REG_LEN = RegLen,
    parameter int ALU_LEN = ALU_Len
) (
    input  logic [REG_LEN-1:0] word,
    input  logic [ALU_LEN-1:0] op,
    output logic [REG_LEN-1:0] data
);
    always_comb begin
        data = word;
        case (op)
            ALU_LB:  data = {{(REG_LEN-8){word[7]}}, word[7:0]};
            ALU_LBU: data = {{(REG_LEN-8){1'b0}}, word[7:0]};
            ALU_LH:  data = {{(REG_LEN-16){word[15]}}, word[15:0]};
            ALU_LHU: data = {{(REG_LEN-16){1'b0}}, word[15:0]};
            default: data = word;
        endcase
    end
endmodule

// File: rtl/mem_stage.sv
// Memory-access stage: byte-serial loads/stores over an 8-bit RAM port,
// one-cycle registered pass-through for everything else.
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int ADDR_LEN     = AddrLen,
    parameter int REG_LEN      = RegLen,
    parameter int REG_ADDR_LEN = RegAddrLen,
    parameter int ALU_LEN      = ALU_Len
) (
    input  logic         clk,
    input  logic         rst,
    mem_stage_if.slave   bus
);
    mem_state_t              state_q, state_d;
    logic [2:0]              cnt_q;
    logic [ALU_LEN-1:0]      op_q;
    logic [REG_LEN-1:0]      wdata_q;
    logic [REG_LEN-1:0]      word_q, word_d, ext_data;
    logic [REG_ADDR_LEN-1:0] rd_addr_q;
    logic                    rd_en_q;
    logic                    accept, last_byte;

    logic                    out_valid_q;
    logic [REG_LEN-1:0]      rd_data_q;
    logic [REG_ADDR_LEN-1:0] rd_addr_o_q;
    logic                    rd_enable_q;
    logic [ADDR_LEN-1:0]     ram_addr_q;
    logic [7:0]              ram_wdata_q;
    logic                    ram_wr_q;

    assign accept    = (state_q == MEM_IDLE) && bus.in_valid;
    assign last_byte = (cnt_q == access_bytes(op_q) - 3'd1);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= MEM_IDLE;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            MEM_IDLE: begin
                if (bus.in_valid) begin
                    if (is_load(bus.alu_op_i))       state_d = MEM_READ;
                    else if (is_store(bus.alu_op_i)) state_d = MEM_WRITE;
                end
            end
            MEM_READ, MEM_WRITE: if (last_byte) state_d = MEM_DONE;
            MEM_DONE: state_d = MEM_IDLE;
            default:  state_d = MEM_IDLE;
        endcase
    end

    // Byte arriving this cycle lands in lane cnt_q; extension sees it before it is stored.
    always_comb begin
        word_d = word_q;
        for (int i = 0; i < REG_LEN / 8; i++) begin
            if (cnt_q == 3'(i)) word_d[8*i +: 8] = bus.ram_rdata_i;
        end
    end

    mem_load_ext #(.REG_LEN(REG_LEN), .ALU_LEN(ALU_LEN)) u_load_ext (
        .word (word_d),
        .op   (op_q),
        .data (ext_data)
    );

    // Operand latches; wdata_q is kept pre-shifted so its low byte is always the next to write.
    always_ff @(posedge clk) begin
        if (accept) begin
            op_q      <= bus.alu_op_i;
            rd_addr_q <= bus.rd_addr_i;
            rd_en_q   <= bus.rd_enable_i;
            wdata_q   <= bus.mem_wdata_i >> 8;
        end else if (state_q == MEM_WRITE) begin
            wdata_q   <= wdata_q >> 8;
        end
        if (state_q == MEM_READ) word_q <= word_d;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            rd_data_q   <= '0;
            rd_addr_o_q <= '0;
            rd_enable_q <= 1'b0;
            ram_addr_q  <= '0;
            ram_wdata_q <= '0;
            ram_wr_q    <= WriteDisable;
        end else begin
            out_valid_q <= 1'b0;
            ram_wr_q    <= WriteDisable;
            case (state_q)
                MEM_IDLE: begin
                    if (bus.in_valid) begin
                        cnt_q <= '0;
                        if (is_load(bus.alu_op_i)) begin
                            ram_addr_q <= bus.mem_addr_i;
                        end else if (is_store(bus.alu_op_i)) begin
                            ram_addr_q  <= bus.mem_addr_i;
                            ram_wdata_q <= bus.mem_wdata_i[7:0];
                            ram_wr_q    <= WriteEnable;
                        end else begin
                            out_valid_q <= 1'b1;
                            rd_data_q   <= bus.rd_data_i;
                            rd_addr_o_q <= bus.rd_addr_i;
                            rd_enable_q <= bus.rd_enable_i;
                        end
                    end
                end
                MEM_READ: begin
                    if (last_byte) begin
                        out_valid_q <= 1'b1;
                        rd_data_q   <= ext_data;
                        rd_addr_o_q <= rd_addr_q;
                        rd_enable_q <= rd_en_q;
                    end else begin
                        cnt_q      <= cnt_q + 3'd1;
                        ram_addr_q <= ram_addr_q + 1'b1;
                    end
                end
                MEM_WRITE: begin
                    if (last_byte) begin
                        out_valid_q <= 1'b1;
                        rd_data_q   <= '0;
                        rd_addr_o_q <= rd_addr_q;
                        rd_enable_q <= 1'b0;
                    end else begin
                        cnt_q       <= cnt_q + 3'd1;
                        ram_addr_q  <= ram_addr_q + 1'b1;
                        ram_wdata_q <= wdata_q[7:0];
                        ram_wr_q    <= WriteEnable;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.stall_o     = (state_q != MEM_IDLE);
    assign bus.out_valid   = out_valid_q;
    assign bus.rd_data_o   = rd_data_q;
    assign bus.rd_addr_o   = rd_addr_o_q;
    assign bus.rd_enable_o = rd_enable_q;
    assign bus.ram_addr_o  = ram_addr_q;
    assign bus.ram_wdata_o = ram_wdata_q;
    assign bus.ram_wr_o    = ram_wr_q;

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: transaction-timeline model checked every cycle plus directed literal checks.
module tb_mem_stage;
    import mem_stage_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    mem_stage_if #(.ADDR_LEN(32), .REG_LEN(32), .REG_ADDR_LEN(5), .ALU_LEN(5)) bus ();

    mem_stage #(.ADDR_LEN(32), .REG_LEN(32), .REG_ADDR_LEN(5), .ALU_LEN(5)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int total = 0;
    int bad   = 0;
    int pulses = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
        end
    endtask

    // Byte RAM (low 8 address bits) with combinational read and a backdoor preload port.
    logic [7:0] ram [256];
    logic       bd_we = 1'b0;
    logic [7:0] bd_addr = 8'h00, bd_data = 8'h00;
    assign bus.ram_rdata_i = ram[bus.ram_addr_o[7:0]];
    always @(posedge clk) begin
        if (bd_we) ram[bd_addr] <= bd_data;
        else if (bus.ram_wr_o) ram[bus.ram_addr_o[7:0]] <= bus.ram_wdata_o;
    end

    // Expected outputs for one cycle.
    typedef struct {
        bit          stall, ov, wr, chk_ram, chk_rda, en;
        logic [31:0] data;
        logic [4:0]  rda;
        logic [31:0] raddr;
        logic [7:0]  wdata;
    } exp_t;

    exp_t        q[$];
    exp_t        cur;
    logic [31:0] h_data;
    logic        h_en;

    function automatic exp_t idle_e();
        exp_t e;
        e = '{default: 0};
        return e;
    endfunction

    function automatic int nbytes(input logic [4:0] op);
        case (op)
            ALU_LB, ALU_LBU, ALU_SB: return 1;
            ALU_LH, ALU_LHU, ALU_SH: return 2;
            ALU_LW, ALU_SW:          return 4;
            default:                 return 0;
        endcase
    endfunction

    function automatic logic [31:0] m_load(input logic [4:0] op, input logic [31:0] addr);
        logic [31:0] v;
        v = 32'd0;
        for (int i = 0; i < nbytes(op); i++)
            v = v + (32'(ram[8'(addr + 32'(i))]) << (8 * i));
        if (op == ALU_LB && v >= 32'd128)   v = v - 32'd256;
        if (op == ALU_LH && v >= 32'd32768) v = v - 32'd65536;
        return v;
    endfunction

    // Lay out the whole cycle-by-cycle timeline of one accepted transaction.
    task automatic push_txn();
        exp_t        e;
        logic [4:0]  op;
        int          n;
        op = bus.alu_op_i;
        n  = nbytes(op);
        if (op inside {ALU_LB, ALU_LH, ALU_LW, ALU_LBU, ALU_LHU}) begin
            for (int k = 1; k <= n; k++) begin
                e = idle_e(); e.stall = 1; e.chk_ram = 1;
                e.raddr = bus.mem_addr_i + 32'(k - 1);
                q.push_back(e);
            end
            e = idle_e(); e.stall = 1; e.ov = 1; e.chk_rda = 1;
            e.data = m_load(op, bus.mem_addr_i); e.en = bus.rd_enable_i; e.rda = bus.rd_addr_i;
            q.push_back(e);
        end else if (op inside {ALU_SB, ALU_SH, ALU_SW}) begin
            for (int k = 1; k <= n; k++) begin
                e = idle_e(); e.stall = 1; e.wr = 1; e.chk_ram = 1;
                e.raddr = bus.mem_addr_i + 32'(k - 1);
                e.wdata = 8'((bus.mem_wdata_i >> (8 * (k - 1))) & 32'hFF);
                q.push_back(e);
            end
            e = idle_e(); e.stall = 1; e.ov = 1;
            q.push_back(e);
        end else begin
            e = idle_e(); e.ov = 1; e.chk_rda = 1;
            e.data = bus.rd_data_i; e.en = bus.rd_enable_i; e.rda = bus.rd_addr_i;
            q.push_back(e);
        end
    endtask

    always @(posedge clk or negedge rst) begin : model
        exp_t e;
        if (!rst) begin
            q.delete();
            cur    <= idle_e();
            h_data <= '0;
            h_en   <= 1'b0;
        end else begin
            if (!cur.stall && bus.in_valid) push_txn();
            if (q.size() > 0) e = q.pop_front();
            else              e = idle_e();
            cur <= e;
            if (e.ov) begin
                h_data <= e.data;
                h_en   <= e.en;
            end
        end
    end

    always @(negedge clk) begin
        if (rst) begin
            check("stall", 32'(bus.stall_o), 32'(cur.stall));
            check("out_valid", 32'(bus.out_valid), 32'(cur.ov));
            check("ram_wr", 32'(bus.ram_wr_o), 32'(cur.wr));
            check("rd_data", bus.rd_data_o, h_data);
            check("rd_enable", 32'(bus.rd_enable_o), 32'(h_en));
            if (cur.ov && cur.chk_rda) check("rd_addr", 32'(bus.rd_addr_o), 32'(cur.rda));
            if (cur.chk_ram) check("ram_addr", bus.ram_addr_o, cur.raddr);
            if (cur.wr) check("ram_wdata", 32'(bus.ram_wdata_o), 32'(cur.wdata));
            if (bus.out_valid) pulses <= pulses + 1;
        end
    end

    task automatic bd(input logic [7:0] a, input logic [7:0] d);
        bd_we = 1'b1; bd_addr = a; bd_data = d;
        @(posedge clk); #1;
        bd_we = 1'b0;
    endtask

    task automatic drive(input logic [4:0] op, input logic [31:0] rdd, input logic [4:0] rda,
                         input logic rde, input logic [31:0] addr, input logic [31:0] wd);
        bus.alu_op_i = op; bus.rd_data_i = rdd; bus.rd_addr_i = rda;
        bus.rd_enable_i = rde; bus.mem_addr_i = addr; bus.mem_wdata_i = wd;
        bus.in_valid = 1'b1;
    endtask

    // Issue one op, return the result and the number of cycles until out_valid.
    task automatic do_op(input string nm, input logic [4:0] op, input logic [31:0] rdd,
                         input logic [4:0] rda, input logic rde, input logic [31:0] addr,
                         input logic [31:0] wd, output logic [31:0] res, output int lat);
        drive(op, rdd, rda, rde, addr, wd);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        lat = 0;
        res = '0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (bus.out_valid) begin
                lat = i;
                res = bus.rd_data_o;
                break;
            end
        end
        if (lat == 0) begin
            total++; bad++;
            $display("FAIL %s_timeout actual=no out_valid required=out_valid within 20 cycles", nm);
        end
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=still running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] res;
        int          lat, start;
        bus.in_valid = 1'b0; bus.alu_op_i = ALU_NOP; bus.rd_data_i = '0; bus.rd_addr_i = '0;
        bus.rd_enable_i = 1'b0; bus.mem_addr_i = '0; bus.mem_wdata_i = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_rd_data", bus.rd_data_o, 32'd0);
        check("rst_rd_addr", 32'(bus.rd_addr_o), 32'd0);
        check("rst_rd_enable", 32'(bus.rd_enable_o), 32'd0);
        check("rst_ram_addr", bus.ram_addr_o, 32'd0);
        check("rst_ram_wdata", 32'(bus.ram_wdata_o), 32'd0);
        check("rst_ram_wr", 32'(bus.ram_wr_o), 32'd0);
        check("rst_stall", 32'(bus.stall_o), 32'd0);

        bd(8'h00, 8'h78); bd(8'h01, 8'h56); bd(8'h02, 8'h34); bd(8'h03, 8'h12);
        bd(8'h20, 8'h80); bd(8'h30, 8'h00); bd(8'h31, 8'h80);
        bd(8'h40, 8'h00); bd(8'h41, 8'h00); bd(8'h42, 8'h00); bd(8'h43, 8'h00);
        @(negedge clk); #2;
        rst = 1'b1;
        @(posedge clk); #1;

        do_op("add", ALU_ADD, 32'h1234, 5'd3, 1'b1, 32'h0, 32'h0, res, lat);
        check("add_data", res, 32'h0000_1234);
        check("add_lat", 32'(lat), 32'd1);

        do_op("lw", ALU_LW, 32'h0, 5'd7, 1'b1, 32'h100, 32'h0, res, lat);
        check("lw_data", res, 32'h1234_5678);
        check("lw_lat", 32'(lat), 32'd5);

        do_op("lb", ALU_LB, 32'h0, 5'd5, 1'b1, 32'h20, 32'h0, res, lat);
        check("lb_data", res, 32'hFFFF_FF80);
        check("lb_lat", 32'(lat), 32'd2);
        do_op("lbu", ALU_LBU, 32'h0, 5'd6, 1'b1, 32'h20, 32'h0, res, lat);
        check("lbu_data", res, 32'h0000_0080);
        do_op("lh", ALU_LH, 32'h0, 5'd8, 1'b1, 32'h30, 32'h0, res, lat);
        check("lh_data", res, 32'hFFFF_8000);
        check("lh_lat", 32'(lat), 32'd3);
        do_op("lhu", ALU_LHU, 32'h0, 5'd9, 1'b1, 32'h30, 32'h0, res, lat);
        check("lhu_data", res, 32'h0000_8000);

        do_op("sh_wrap", ALU_SH, 32'h0, 5'd2, 1'b1, 32'hFFFF_FFFF, 32'hAABB_CCDD, res, lat);
        check("sh_lat", 32'(lat), 32'd3);
        check("sh_rd_data", res, 32'h0);
        check("sh_byte_ff", 32'(ram[8'hFF]), 32'h0000_00DD);
        check("sh_byte_00", 32'(ram[8'h00]), 32'h0000_00CC);

        do_op("sw", ALU_SW, 32'h0, 5'd1, 1'b1, 32'h50, 32'hCAFE_BABE, res, lat);
        check("sw_lat", 32'(lat), 32'd5);
        do_op("lw_back", ALU_LW, 32'h0, 5'd10, 1'b1, 32'h50, 32'h0, res, lat);
        check("lw_back_data", res, 32'hCAFE_BABE);

        do_op("branch", ALU_BRANCH, 32'hDEAD_BEEF, 5'd11, 1'b0, 32'h20, 32'h0, res, lat);
        check("branch_data", res, 32'hDEAD_BEEF);
        check("branch_lat", 32'(lat), 32'd1);

        // in_valid held through a busy load: the second op must be taken exactly once.
        start = pulses;
        drive(ALU_LW, 32'h0, 5'd12, 1'b1, 32'h100, 32'h0);
        @(posedge clk); #1;
        drive(ALU_ADD, 32'h55, 5'd9, 1'b1, 32'h0, 32'h0);
        repeat (6) @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("hold_pulses", 32'(pulses - start), 32'd2);
        check("hold_last_data", bus.rd_data_o, 32'h0000_0055);

        // Reset in the middle of a word store.
        drive(ALU_SW, 32'h0, 5'd4, 1'b1, 32'h40, 32'h1122_3344);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        check("mid_rst_ram_wr", 32'(bus.ram_wr_o), 32'd0);
        check("mid_rst_stall", 32'(bus.stall_o), 32'd0);
        check("mid_rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("mid_rst_rd_data", bus.rd_data_o, 32'd0);
        check("mid_rst_rd_enable", 32'(bus.rd_enable_o), 32'd0);
        check("mid_rst_rd_addr", 32'(bus.rd_addr_o), 32'd0);
        check("mid_rst_ram_addr", bus.ram_addr_o, 32'd0);
        check("mid_rst_ram_wdata", 32'(bus.ram_wdata_o), 32'd0);
        @(negedge clk); #2;
        rst = 1'b1;
        check("partial_b0", 32'(ram[8'h40]), 32'h0000_0044);
        check("partial_b1", 32'(ram[8'h41]), 32'h0000_0033);
        check("partial_b2", 32'(ram[8'h42]), 32'h0000_0000);
        @(posedge clk); #1;

        do_op("add_after_rst", ALU_ADD, 32'h0000_BEEF, 5'd13, 1'b1, 32'h0, 32'h0, res, lat);
        check("add_after_rst_data", res, 32'h0000_BEEF);
        check("add_after_rst_lat", 32'(lat), 32'd1);

        repeat (2) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Memory-access stage directly downstream of the execute stage; consumes its result/address/store-data/op bundle.
- Performs byte-serial loads and stores over an 8-bit RAM port; non-memory ops pass through with one registered cycle.
- Produces the writeback bundle and a stall toward upstream while a multi-cycle access is in flight.

Parameters:
- ADDR_LEN, 32, address width.
- REG_LEN, 32, data width.
- REG_ADDR_LEN, 5, register index width.
- ALU_LEN, 5, op-code width; encodings come from the shared config package.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- in_valid  in  1  upstream bundle valid this cycle.
- rd_data_i  in  REG_LEN  ALU result for non-memory ops.
- rd_addr_i  in  REG_ADDR_LEN  destination register.
- rd_enable_i  in  1  writeback enable.
- mem_addr_i  in  ADDR_LEN  effective address for load/store.
- alu_op_i  in  ALU_LEN  op code.
- mem_wdata_i  in  REG_LEN  store data.
- stall_o  out  1  high while busy; upstream holds its bundle.
- out_valid  out  1  one-cycle pulse, writeback bundle valid.
- rd_data_o  out  REG_LEN  writeback data.
- rd_addr_o  out  REG_ADDR_LEN  writeback register.
- rd_enable_o  out  1  writeback enable.
- ram_addr_o  out  ADDR_LEN  RAM byte address.
- ram_wdata_o  out  8  RAM write byte.
- ram_wr_o  out  1  RAM write strobe.
- ram_rdata_i  in  8  RAM read byte; valid the cycle after its address is presented.

Behaviour:
- Reset values (rst low, asynchronous): state IDLE; byte counter 0; out_valid 0; rd_data_o 0; rd_addr_o 0; rd_enable_o 0; ram_addr_o 0; ram_wdata_o 0; ram_wr_o 0.
- Reset has priority over everything. Reset mid-access abandons the op immediately: ram_wr_o drops at once, and a partially written store stays partial.
- Sizes: N=1 for LB, LBU, SB; N=2 for LH, LHU, SH; N=4 for LW, SW. Byte order is little-endian.
- Byte addresses are mem_addr_i+i (i=0..N-1), mod 2^ADDR_LEN, so they wrap at 0xFFFFFFFF. There is no alignment check.
- States:
  - IDLE: accept when in_valid. Non-memory op -> stay IDLE, register the pass-through bundle. Load -> READ. Store -> WRITE. Latch addr, op, wdata, rd_addr and rd_enable.
  - READ: at acceptance edge T, ram_addr_o = addr+0. At edge T+k (k=1..N), capture ram_rdata_i as byte k-1; for k<N also present addr+k. After edge T+N, go to DONE.
  - WRITE: cycles T+1..T+N drive ram_addr_o = addr+i, ram_wdata_o = wdata[8i+7:8i], ram_wr_o = 1. After the last byte, go to DONE.
  - DONE: out_valid = 1 for one cycle, then IDLE. A new in_valid is not accepted in DONE.
- Latency:
  - Non-memory op: out_valid at T+1, with rd_data_o = rd_data_i.
  - Load or store: out_valid at T+N+1.
- stall_o = (state != IDLE), combinational. in_valid while stall_o is high is ignored and not queued.
- Load extension:
  - LB sign-extends bit 7; LH sign-extends bit 15.
  - LBU and LHU zero-extend; LW uses the 32 bits as assembled.
- Store: rd_enable_o = 0 and rd_data_o = 0 on its out_valid.
- BRANCH and unknown ops take the pass-through path.
- ram_wr_o is 0 in every cycle that is not a store byte cycle.
- ram_addr_o holds its last value when idle.
- out_valid is 0 when no result completes. Between pulses, rd_*_o hold their last values.

Decomposition:
- Shared config package: ALU op encodings (LB..SW, BRANCH, etc.), ResetEnable-style constants, widths RegLen, AddrLen, RegAddrLen, ALU_Len, and the state encodings for this block.
- One combinational sub-module, mem_load_ext: assembled 32-bit word + op -> extended rd_data.

Test Plan:
- ADD, rd_data_i=0x1234, rd_addr_i=3, in_valid for 1 cycle -> next cycle out_valid=1, rd_data_o=0x1234, rd_addr_o=3, stall_o never high.
- LW addr 0x100, RAM bytes 0x78,0x56,0x34,0x12 -> ram_addr_o 0x100..0x103 on consecutive cycles, stall_o high 5 cycles, out_valid at T+5 with 0x12345678.
- LB/LBU addr 0x20, byte 0x80 -> 0xFFFFFF80 / 0x00000080. LH/LHU bytes 0x00,0x80 -> 0xFFFF8000 / 0x00008000.
- SH addr 0xFFFFFFFF, wdata 0xAABBCCDD -> write 0xDD@0xFFFFFFFF then 0xCC@0x00000000. out_valid at T+3 with rd_enable_o=0.
- SW accepted, rst pulled low after 2 bytes -> ram_wr_o low immediately, all outputs at reset values; after release, an ADD is accepted normally.
- in_valid with a different op held high while a LW is busy -> ignored until IDLE, then accepted exactly once (out_valid count = 2).
